// File: rtl/instr_sequencer.sv
// Program sequencer: issues words from a small local program memory to the CPU,
// holding each one for its class-specific cycle count; halts on a halt word or end of memory.
// Latency: start sampled at edge T -> first word on instruction after T; abort/loads act on the next edge.
module instr_sequencer #(
  parameter int INSTR_WIDTH    = 20,
  parameter int PROG_ADDR_BITS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load_en,
  input  logic [PROG_ADDR_BITS-1:0] load_addr,
  input  logic [INSTR_WIDTH-1:0]    load_data,
  input  logic                      start,
  input  logic                      abort,
  output logic [INSTR_WIDTH-1:0]    instruction,
  output logic [PROG_ADDR_BITS-1:0] pc,
  output logic                      busy,
  output logic                      halted,
  output logic                      instr_done,
  output logic                      load_err,
  output logic [7:0]                instr_count
);

  localparam int DEPTH = 2 ** PROG_ADDR_BITS;

  typedef enum logic [1:0] {IDLE, ISSUE, HALT} state_t;

  state_t                    state, state_n;
  logic [INSTR_WIDTH-1:0]    mem [DEPTH];
  logic [2:0]                hold, hold_n;
  logic [INSTR_WIDTH-1:0]    instr_n;
  logic [PROG_ADDR_BITS-1:0] pc_n;
  logic                      busy_n, halted_n, done_n, load_err_n;
  logic [7:0]                cnt_n;
  logic                      do_fetch, first_n;
  logic                      mem_we;
  logic [PROG_ADDR_BITS-1:0] fetch_addr;
  logic [INSTR_WIDTH-1:0]    fetch_word;
  logic [1:0]                fetch_cls;

  // Only a stopped sequencer may rewrite its program.
  assign mem_we     = load_en && (state != ISSUE);
  // From IDLE/HALT the fetch is always word 0 (start); during ISSUE it is the successor.
  assign fetch_addr = (state == ISSUE) ? pc + PROG_ADDR_BITS'(1) : '0;
  assign fetch_word = mem[fetch_addr];
  assign fetch_cls  = fetch_word[INSTR_WIDTH-1 -: 2];

  // Program memory write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[load_addr] <= load_data;
  end

  // Next-state and next-output decision, abort taking priority over everything.
  always_comb begin
    state_n    = state;
    instr_n    = instruction;
    pc_n       = pc;
    busy_n     = busy;
    halted_n   = halted;
    cnt_n      = instr_count;
    hold_n     = hold;
    load_err_n = load_en && (state == ISSUE);
    do_fetch   = 1'b0;
    first_n    = 1'b0;
    if (abort) begin
      state_n  = IDLE;
      instr_n  = '0;
      busy_n   = 1'b0;
      halted_n = 1'b0;
      hold_n   = '0;
    end else begin
      case (state)
        IDLE, HALT: begin
          // A simultaneous load wins; start must be re-presented.
          if (start && !load_en) begin
            pc_n     = '0;
            cnt_n    = '0;
            halted_n = 1'b0;
            do_fetch = 1'b1;
            first_n  = 1'b1;
          end
        end
        ISSUE: begin
          if (hold == 3'd0) begin
            if (instr_count != 8'hFF) cnt_n = instr_count + 8'd1;
            if (&pc) begin
              state_n  = HALT;
              instr_n  = '0;
              busy_n   = 1'b0;
              halted_n = 1'b1;
            end else begin
              pc_n     = pc + PROG_ADDR_BITS'(1);
              do_fetch = 1'b1;
            end
          end else begin
            hold_n = hold - 3'd1;
          end
        end
        default: state_n = IDLE;
      endcase
      if (do_fetch) begin
        if (fetch_cls == 2'b00) begin
          // Halt word: no issue cycles spent on it.
          state_n  = HALT;
          instr_n  = '0;
          busy_n   = 1'b0;
          halted_n = 1'b1;
          hold_n   = '0;
        end else begin
          // Hold counts remaining cycles after this one; first word gets one extra
          // so the CPU control unit can leave its reset state.
          state_n = ISSUE;
          instr_n = fetch_word;
          busy_n  = 1'b1;
          hold_n  = ((fetch_cls == 2'b10) ? 3'd3 : 3'd2) + {2'b00, first_n};
        end
      end
    end
    done_n = (state_n == ISSUE) && (hold_n == 3'd0);
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      instruction <= '0;
      pc          <= '0;
      busy        <= 1'b0;
      halted      <= 1'b0;
      instr_done  <= 1'b0;
      load_err    <= 1'b0;
      instr_count <= '0;
      hold        <= '0;
    end else begin
      state       <= state_n;
      instruction <= instr_n;
      pc          <= pc_n;
      busy        <= busy_n;
      halted      <= halted_n;
      instr_done  <= done_n;
      load_err    <= load_err_n;
      instr_count <= cnt_n;
      hold        <= hold_n;
    end
  end

endmodule
